pc_sched: RTL and testbench
===========================

Name: pc_sched

Overview:
Next-generation program counter with multi-context preemptive scheduling support. It holds the fetch address plus a table of NUM_CTX saved user-context PCs. It counts a per-dispatch quantum and automatically saves and restores context PCs on preemption, halt and dispatch. It sits at the head of the fetch stage, drives the instruction-memory address, and hands control back to the OS region at address 0.

Parameters:
ADDR_WIDTH, 32, width of fetch/jump/saved addresses
NUM_CTX, 4, number of user contexts (power of 2, >=2)
CTX_WIDTH, $clog2(NUM_CTX), context index width
OS_LIMIT, 512, first address of user space; addresses below it are OS region
QUANTUM_WIDTH, 16, width of quantum counter/limit

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold all state this cycle (pipeline freeze)
halt  in  1  running program executed halt
jump  in  1  take jump_address this cycle
jump_address  in  ADDR_WIDTH  jump/branch target
write_quantum  in  1  load quantum into max_quantum
quantum  in  QUANTUM_WIDTH  new quantum limit; 0 = preemption disabled
dispatch  in  1  OS request: resume context dispatch_ctx
dispatch_ctx  in  CTX_WIDTH  context to resume
init_ctx  in  1  OS writes init_address into saved[dispatch_ctx], clears its done flag
init_address  in  ADDR_WIDTH  initial PC for init_ctx
output_address  out  ADDR_WIDTH  current fetch address
user_mode  out  1  1 while a user context runs
current_ctx  out  CTX_WIDTH  context running or last run
program_ended  out  1  1-cycle pulse: running context halted
quantum_expired  out  1  1-cycle pulse: running context preempted
ctx_done  out  NUM_CTX  per-context halted flags

Behaviour:
- Reset (reset=0, async) gives these values: output_address=0, mode=OS, current_ctx=0, quantum counter=0, max_quantum=0, all saved PCs=0, ctx_done=all ones, pulses=0.
- write_quantum is sampled every cycle, even under stall; it updates max_quantum next edge and does not reset the running counter.
- init_ctx is sampled every cycle regardless of stall or mode. If init_ctx and dispatch target the same ctx in the same cycle, init wins; dispatch then resumes at init_address.
- With stall=1, all other state holds and the pulses are 0.
- States: OS, USER.
- OS state, priority halt > dispatch > jump > increment:
  - halt in OS: output_address=0, no pulse.
  - dispatch: output_address<=saved[dispatch_ctx], current_ctx<=dispatch_ctx, counter<=0, go USER. Dispatching a ctx with done=1 is ignored (acts as increment).
  - Otherwise jump/increment as a plain PC; the counter stays 0.
- USER state, priority halt > expiry > jump > increment:
  - halt: ctx_done[current_ctx]<=1, program_ended pulse, output_address<=0, go OS.
  - expiry: condition is max_quantum!=0 and counter+1 >= max_quantum on an advancing cycle. Effects: saved[current_ctx]<=next address (jump_address if jump else output_address+1), quantum_expired pulse, output_address<=0, go OS. The instruction at the expiring cycle is therefore not lost.
  - Otherwise: counter+1 (saturates at all ones), address advances.
- dispatch while in USER is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- Pulses are registered and valid the cycle after the causing edge.

Optional Feature:
PC_BOUNDS_CHECK_EN.
- Defined: an extra output port fault (1). In USER, a jump to an address < OS_LIMIT, or an increment wrapping below OS_LIMIT, traps:
  - fault pulse;
  - ctx_done[current_ctx]<=1;
  - output_address<=0;
  - go OS.
  - Priority is below halt and above expiry.
- Undefined: there is no fault port, and user jumps anywhere are honoured.

Decomposition:
- Package pc_sched_pkg: mode enum {MODE_OS, MODE_USER}, OS_ENTRY constant (0), priority-encoding localparams.
- Sub-module pc_ctx_table: NUM_CTX×ADDR_WIDTH saved-PC register file plus done flags. It has one write port (save/init) and one async read port (dispatch_ctx), with async active-low reset.

Test Plan:
1. Reset mid-run in USER at address 600 -> output_address=0 immediately, ctx_done=4'b1111, user_mode=0.
2. init_ctx ctx1=512, quantum=3, dispatch ctx1 -> addresses 512,513,514; then quantum_expired pulse, address 0, saved[1]=515. Redispatch -> resumes at 515.
3. USER at 520, halt and jump same cycle -> program_ended pulse, ctx_done[1]=1, address 0. A later dispatch ctx1 is ignored and the OS PC increments.
4. quantum=0, dispatch ctx2 at 700 -> runs 1000+ cycles with no expiry. Counter saturates with no wrap-triggered expiry.
5. stall held 5 cycles at counter=2 of quantum 3 -> no expiry during stall; expiry occurs on the first unstalled cycle.
6. With PC_BOUNDS_CHECK_EN, USER jump to 100 -> fault pulse, address 0, ctx_done set. Without the macro -> address 100, still USER.

Source files
------------

// File: rtl/pc_sched_pkg.sv
// pc_sched_pkg: shared types and constants for the preemptive program counter.
// Holds the run-mode enum, the OS entry address and the action codes used to
// rank the competing per-cycle events (halt, fault, expiry, dispatch, jump, increment).
package pc_sched_pkg;

  typedef enum logic {
    MODE_OS   = 1'b0,
    MODE_USER = 1'b1
  } mode_e;

  // Control always returns to the OS at this address.
  localparam int OS_ENTRY = 0;

  // Action codes, listed from highest to lowest priority.
  typedef logic [2:0] act_t;
  localparam act_t ACT_HOLD     = 3'd0;
  localparam act_t ACT_HALT     = 3'd1;
  localparam act_t ACT_FAULT    = 3'd2;
  localparam act_t ACT_EXPIRE   = 3'd3;
  localparam act_t ACT_DISPATCH = 3'd4;
  localparam act_t ACT_JUMP     = 3'd5;
  localparam act_t ACT_INC      = 3'd6;

endpackage

// File: rtl/pc_sched_if.sv
// pc_sched_if: control and status bundle between the fetch/OS side (master)
// and the scheduling program counter (slave).
// The fault signal exists only when PC_BOUNDS_CHECK_EN is defined.
interface pc_sched_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_CTX       = 4,
  parameter int CTX_WIDTH     = $clog2(NUM_CTX),
  parameter int QUANTUM_WIDTH = 16
);
  logic                     stall;
  logic                     halt;
  logic                     jump;
  logic [ADDR_WIDTH-1:0]    jump_address;
  logic                     write_quantum;
  logic [QUANTUM_WIDTH-1:0] quantum;
  logic                     dispatch;
  logic [CTX_WIDTH-1:0]     dispatch_ctx;
  logic                     init_ctx;
  logic [ADDR_WIDTH-1:0]    init_address;

  logic [ADDR_WIDTH-1:0]    output_address;
  logic                     user_mode;
  logic [CTX_WIDTH-1:0]     current_ctx;
  logic                     program_ended;
  logic                     quantum_expired;
  logic [NUM_CTX-1:0]       ctx_done;
`ifdef PC_BOUNDS_CHECK_EN
  logic                     fault;
`endif

  modport master (
`ifdef PC_BOUNDS_CHECK_EN
    input  fault,
`endif
    output stall, halt, jump, jump_address, write_quantum, quantum,
    output dispatch, dispatch_ctx, init_ctx, init_address,
    input  output_address, user_mode, current_ctx, program_ended,
    input  quantum_expired, ctx_done
  );

  modport slave (
`ifdef PC_BOUNDS_CHECK_EN
    output fault,
`endif
    input  stall, halt, jump, jump_address, write_quantum, quantum,
    input  dispatch, dispatch_ctx, init_ctx, init_address,
    output output_address, user_mode, current_ctx, program_ended,
    output quantum_expired, ctx_done
  );

endinterface

// File: rtl/pc_sched_ctx_table.sv
// pc_ctx_table: saved user-context PCs plus per-context done flags.
// One write port (save or OS init), an extra done-set port for halts/traps,
// and one asynchronous read port addressed by the dispatch context.
module pc_ctx_table
  import pc_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CTX    = 4,
  parameter int CTX_WIDTH  = $clog2(NUM_CTX)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wrEn_i,
  input  logic [CTX_WIDTH-1:0]  wrIdx_i,
  input  logic [ADDR_WIDTH-1:0] wrData_i,
  input  logic                  clrDone_i,
  input  logic                  setDone_i,
  input  logic [CTX_WIDTH-1:0]  setIdx_i,
  input  logic [CTX_WIDTH-1:0]  rdIdx_i,
  output logic [ADDR_WIDTH-1:0] rdData_o,
  output logic                  rdDone_o,
  output logic [NUM_CTX-1:0]    done_o
);

  logic [ADDR_WIDTH-1:0] saved_q [NUM_CTX];
  logic [NUM_CTX-1:0]    done_q;

  // Register file update; an init clearing a flag overrides a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        saved_q[i] <= ADDR_WIDTH'(OS_ENTRY);
      end
      done_q <= '1;
    end else begin
      if (wrEn_i) begin
        saved_q[wrIdx_i] <= wrData_i;
      end
      if (setDone_i) begin
        done_q[setIdx_i] <= 1'b1;
      end
      if (wrEn_i && clrDone_i) begin
        done_q[wrIdx_i] <= 1'b0;
      end
    end
  end

  assign rdData_o = saved_q[rdIdx_i];
  assign rdDone_o = done_q[rdIdx_i];
  assign done_o   = done_q;

endmodule

// File: rtl/pc_sched.sv
// pc_sched: fetch-address program counter with preemptive multi-context scheduling.
// Runs either the OS or one user context, counts a per-dispatch quantum and saves
// the interrupted user PC on preemption. Optional feature macro: PC_BOUNDS_CHECK_EN
// (user jumps below OS_LIMIT or wrapping increments trap back to the OS).
module pc_sched
  import pc_sched_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_CTX       = 4,
  parameter int CTX_WIDTH     = $clog2(NUM_CTX),
  parameter int OS_LIMIT      = 512,
  parameter int QUANTUM_WIDTH = 16
) (
  input logic       clock,
  input logic       reset,
  pc_sched_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] OS_ENTRY_ADDR = ADDR_WIDTH'(OS_ENTRY);
  localparam logic [ADDR_WIDTH-1:0] USER_BASE     = ADDR_WIDTH'(OS_LIMIT);

  mode_e                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic [CTX_WIDTH-1:0]     ctx_q, ctx_d;
  logic [QUANTUM_WIDTH-1:0] cnt_q, cnt_d;
  logic [QUANTUM_WIDTH-1:0] maxQuantum_q, maxQuantum_d;
  logic                     programEnded_q, programEnded_d;
  logic                     quantumExpired_q, quantumExpired_d;
`ifdef PC_BOUNDS_CHECK_EN
  logic                     fault_q, fault_d;
`endif

  logic                     tblWrEn;
  logic [CTX_WIDTH-1:0]     tblWrIdx;
  logic [ADDR_WIDTH-1:0]    tblWrData;
  logic                     tblClrDone;
  logic                     tblSetDone;
  logic [CTX_WIDTH-1:0]     tblSetIdx;
  logic [ADDR_WIDTH-1:0]    tblRdData;
  logic                     tblRdDone;
  logic [NUM_CTX-1:0]       tblDone;

  logic [ADDR_WIDTH-1:0]    nextAddr;
  logic [QUANTUM_WIDTH:0]   cntInc;
  logic                     expire;
  logic                     boundsFault;
  logic                     dispCtxDone;
  logic [ADDR_WIDTH-1:0]    dispAddr;
  act_t                     act;

  pc_ctx_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_CTX    (NUM_CTX),
    .CTX_WIDTH  (CTX_WIDTH)
  ) u_ctx_table (
    .clk_i     (clock),
    .rst_ni    (reset),
    .wrEn_i    (tblWrEn),
    .wrIdx_i   (tblWrIdx),
    .wrData_i  (tblWrData),
    .clrDone_i (tblClrDone),
    .setDone_i (tblSetDone),
    .setIdx_i  (tblSetIdx),
    .rdIdx_i   (bus.dispatch_ctx),
    .rdData_o  (tblRdData),
    .rdDone_o  (tblRdDone),
    .done_o    (tblDone)
  );

  // The counter is widened by one bit so the expiry compare never sees a wrap.
  assign nextAddr    = bus.jump ? bus.jump_address : pc_q + ADDR_WIDTH'(1);
  assign cntInc      = {1'b0, cnt_q} + (QUANTUM_WIDTH + 1)'(1);
  assign expire      = (maxQuantum_q != '0) && (cntInc >= {1'b0, maxQuantum_q});
  assign boundsFault = bus.jump ? (bus.jump_address < USER_BASE) : (pc_q == '1);
  // A same-cycle init of the dispatched context takes effect for that dispatch.
  assign dispCtxDone = bus.init_ctx ? 1'b0 : tblRdDone;
  assign dispAddr    = bus.init_ctx ? bus.init_address : tblRdData;

`ifndef PC_BOUNDS_CHECK_EN
  logic unusedBoundsFault;
  assign unusedBoundsFault = boundsFault;
`endif

  // Pick the winning event for this cycle and derive all next-state values.
  always_comb begin
    mode_d           = mode_q;
    pc_d             = pc_q;
    ctx_d            = ctx_q;
    cnt_d            = cnt_q;
    maxQuantum_d     = bus.write_quantum ? bus.quantum : maxQuantum_q;
    programEnded_d   = 1'b0;
    quantumExpired_d = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
    fault_d          = 1'b0;
`endif
    // The OS init owns the table write port; it also wins over an expiry save.
    tblWrEn          = bus.init_ctx;
    tblWrIdx         = bus.dispatch_ctx;
    tblWrData        = bus.init_address;
    tblClrDone       = bus.init_ctx;
    tblSetDone       = 1'b0;
    tblSetIdx        = ctx_q;
    act              = ACT_HOLD;

    if (!bus.stall) begin
      if (mode_q == MODE_OS) begin
        if (bus.halt)                             act = ACT_HALT;
        else if (bus.dispatch && !dispCtxDone)    act = ACT_DISPATCH;
        else if (bus.jump)                        act = ACT_JUMP;
        else                                      act = ACT_INC;
      end else begin
        if (bus.halt)                             act = ACT_HALT;
`ifdef PC_BOUNDS_CHECK_EN
        else if (boundsFault)                     act = ACT_FAULT;
`endif
        else if (expire)                          act = ACT_EXPIRE;
        else if (bus.jump)                        act = ACT_JUMP;
        else                                      act = ACT_INC;
      end
    end

    case (act)
      ACT_HALT: begin
        pc_d   = OS_ENTRY_ADDR;
        cnt_d  = '0;
        mode_d = MODE_OS;
        if (mode_q == MODE_USER) begin
          programEnded_d = 1'b1;
          tblSetDone     = 1'b1;
        end
      end
      ACT_FAULT: begin
        pc_d       = OS_ENTRY_ADDR;
        cnt_d      = '0;
        mode_d     = MODE_OS;
        tblSetDone = 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
        fault_d    = 1'b1;
`endif
      end
      ACT_EXPIRE: begin
        pc_d             = OS_ENTRY_ADDR;
        cnt_d            = '0;
        mode_d           = MODE_OS;
        quantumExpired_d = 1'b1;
        if (!bus.init_ctx) begin
          tblWrEn    = 1'b1;
          tblWrIdx   = ctx_q;
          tblWrData  = nextAddr;
          tblClrDone = 1'b0;
        end
      end
      ACT_DISPATCH: begin
        pc_d   = dispAddr;
        ctx_d  = bus.dispatch_ctx;
        cnt_d  = '0;
        mode_d = MODE_USER;
      end
      ACT_JUMP, ACT_INC: begin
        pc_d = nextAddr;
        if ((mode_q == MODE_USER) && (cnt_q != '1)) begin
          cnt_d = cnt_q + QUANTUM_WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // State register with asynchronous active-low reset into the OS entry point.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q           <= MODE_OS;
      pc_q             <= OS_ENTRY_ADDR;
      ctx_q            <= '0;
      cnt_q            <= '0;
      maxQuantum_q     <= '0;
      programEnded_q   <= 1'b0;
      quantumExpired_q <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q          <= 1'b0;
`endif
    end else begin
      mode_q           <= mode_d;
      pc_q             <= pc_d;
      ctx_q            <= ctx_d;
      cnt_q            <= cnt_d;
      maxQuantum_q     <= maxQuantum_d;
      programEnded_q   <= programEnded_d;
      quantumExpired_q <= quantumExpired_d;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q          <= fault_d;
`endif
    end
  end

  assign bus.output_address  = pc_q;
  assign bus.user_mode       = (mode_q == MODE_USER);
  assign bus.current_ctx     = ctx_q;
  assign bus.program_ended   = programEnded_q;
  assign bus.quantum_expired = quantumExpired_q;
  assign bus.ctx_done        = tblDone;
`ifdef PC_BOUNDS_CHECK_EN
  assign bus.fault           = fault_q;
`endif

endmodule

// File: tb/tb_pc_sched.sv
// tb_pc_sched: table-driven scoreboard bench for pc_sched.
// Each vector carries its stimulus and the outputs expected one edge later;
// expectations are queued when driven and popped after the edge.
// A narrow quantum counter is used so saturation is reached in a few hundred cycles.
module tb_pc_sched;

  localparam int AW = 32;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int QW = 8;

  typedef struct {
    string         name;
    logic          stall;
    logic          halt;
    logic          jump;
    logic [AW-1:0] jaddr;
    logic          disp;
    logic [CW-1:0] dctx;
    logic          init;
    logic [AW-1:0] iaddr;
    logic          wq;
    logic [QW-1:0] q;
    logic [AW-1:0] eAddr;
    logic          eUser;
    logic [CW-1:0] eCtx;
    logic          ePend;
    logic          eQexp;
    logic          eFault;
    logic [NC-1:0] eDone;
  } vec_t;

  logic clock;
  logic reset;
  vec_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  pc_sched_if #(.ADDR_WIDTH(AW), .NUM_CTX(NC), .CTX_WIDTH(CW), .QUANTUM_WIDTH(QW)) bus ();

  pc_sched #(
    .ADDR_WIDTH    (AW),
    .NUM_CTX       (NC),
    .CTX_WIDTH     (CW),
    .OS_LIMIT      (512),
    .QUANTUM_WIDTH (QW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stops advancing.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string n, logic [AW-1:0] a, logic u, logic [CW-1:0] c, logic [NC-1:0] d);
    vec_t v;
    v.name  = n;     v.stall = 1'b0;  v.halt   = 1'b0;  v.jump  = 1'b0;
    v.jaddr = '0;    v.disp  = 1'b0;  v.dctx   = '0;    v.init  = 1'b0;
    v.iaddr = '0;    v.wq    = 1'b0;  v.q      = '0;
    v.eAddr = a;     v.eUser = u;     v.eCtx   = c;     v.ePend = 1'b0;
    v.eQexp = 1'b0;  v.eFault = 1'b0; v.eDone  = d;
    return v;
  endfunction

  function automatic vec_t withInit(vec_t v, logic [CW-1:0] c, logic [AW-1:0] a);
    v.init = 1'b1; v.dctx = c; v.iaddr = a; return v;
  endfunction
  function automatic vec_t withDisp(vec_t v, logic [CW-1:0] c);
    v.disp = 1'b1; v.dctx = c; return v;
  endfunction
  function automatic vec_t withJump(vec_t v, logic [AW-1:0] a);
    v.jump = 1'b1; v.jaddr = a; return v;
  endfunction
  function automatic vec_t withQ(vec_t v, logic [QW-1:0] q);
    v.wq = 1'b1; v.q = q; return v;
  endfunction
  function automatic vec_t withHalt(vec_t v);
    v.halt = 1'b1; return v;
  endfunction
  function automatic vec_t withStall(vec_t v);
    v.stall = 1'b1; return v;
  endfunction
  function automatic vec_t withPend(vec_t v);
    v.ePend = 1'b1; return v;
  endfunction
  function automatic vec_t withQexp(vec_t v);
    v.eQexp = 1'b1; return v;
  endfunction
  function automatic vec_t withFault(vec_t v);
    v.eFault = 1'b1; return v;
  endfunction

  // Drive one vector, queue its expectation and advance past the next edge.
  task automatic applyStimulus(input vec_t v);
    bus.stall         = v.stall;
    bus.halt          = v.halt;
    bus.jump          = v.jump;
    bus.jump_address  = v.jaddr;
    bus.dispatch      = v.disp;
    bus.dispatch_ctx  = v.dctx;
    bus.init_ctx      = v.init;
    bus.init_address  = v.iaddr;
    bus.write_quantum = v.wq;
    bus.quantum       = v.q;
    expQ.push_back(v);
    @(posedge clock);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput();
    vec_t e;
    logic actFault;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard: got empty queue, required a queued expectation");
      return;
    end
    e = expQ.pop_front();
`ifdef PC_BOUNDS_CHECK_EN
    actFault = bus.fault;
`else
    actFault = 1'b0;
`endif
    if (bus.output_address !== e.eAddr || bus.user_mode !== e.eUser ||
        bus.current_ctx !== e.eCtx || bus.program_ended !== e.ePend ||
        bus.quantum_expired !== e.eQexp || actFault !== e.eFault ||
        bus.ctx_done !== e.eDone) begin
      failCount++;
      $display("[TB] FAIL %s: got addr=%0d user=%0b ctx=%0d end=%0b qexp=%0b flt=%0b done=%b, required addr=%0d user=%0b ctx=%0d end=%0b qexp=%0b flt=%0b done=%b",
               e.name, bus.output_address, bus.user_mode, bus.current_ctx, bus.program_ended,
               bus.quantum_expired, actFault, bus.ctx_done,
               e.eAddr, e.eUser, e.eCtx, e.ePend, e.eQexp, e.eFault, e.eDone);
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    vec_t tbl[$];
    vec_t idle;

    tbl.push_back(withInit(withQ(mk("init ctx1", 32'd1, 1'b0, 2'd0, 4'b1101), 8'd3), 2'd1, 32'd512));
    tbl.push_back(withDisp(mk("dispatch ctx1", 32'd512, 1'b1, 2'd1, 4'b1101), 2'd1));
    tbl.push_back(mk("user run 513", 32'd513, 1'b1, 2'd1, 4'b1101));
    tbl.push_back(mk("user run 514", 32'd514, 1'b1, 2'd1, 4'b1101));
    tbl.push_back(withQexp(mk("quantum expiry", 32'd0, 1'b0, 2'd1, 4'b1101)));
    tbl.push_back(mk("os after expiry", 32'd1, 1'b0, 2'd1, 4'b1101));
    tbl.push_back(withDisp(mk("redispatch resumes", 32'd515, 1'b1, 2'd1, 4'b1101), 2'd1));
    tbl.push_back(mk("user run 516", 32'd516, 1'b1, 2'd1, 4'b1101));
    tbl.push_back(withJump(mk("user jump 520", 32'd520, 1'b1, 2'd1, 4'b1101), 32'd520));
    tbl.push_back(withPend(withJump(withHalt(mk("halt beats jump", 32'd0, 1'b0, 2'd1, 4'b1111)), 32'd999)));
    tbl.push_back(withDisp(mk("dispatch done ctx", 32'd1, 1'b0, 2'd1, 4'b1111), 2'd1));
    tbl.push_back(withJump(mk("os jump", 32'd40, 1'b0, 2'd1, 4'b1111), 32'd40));
    tbl.push_back(withHalt(mk("os halt", 32'd0, 1'b0, 2'd1, 4'b1111)));
    tbl.push_back(mk("os increment", 32'd1, 1'b0, 2'd1, 4'b1111));
    tbl.push_back(withInit(withQ(mk("quantum off init2", 32'd2, 1'b0, 2'd1, 4'b1011), 8'd0), 2'd2, 32'd700));
    tbl.push_back(withDisp(mk("dispatch ctx2", 32'd700, 1'b1, 2'd2, 4'b1011), 2'd2));

    idle  = mk("idle", 32'd0, 1'b0, 2'd0, 4'b1111);
    reset = 1'b0;
    bus.stall = 1'b0; bus.halt = 1'b0; bus.jump = 1'b0; bus.jump_address = '0;
    bus.dispatch = 1'b0; bus.dispatch_ctx = '0; bus.init_ctx = 1'b0; bus.init_address = '0;
    bus.write_quantum = 1'b0; bus.quantum = '0;
    repeat (2) @(posedge clock);
    #1;
    expQ.push_back(mk("reset state", 32'd0, 1'b0, 2'd0, 4'b1111));
    checkOutput();
    reset = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Preemption disabled: long run, counter saturates without a wrap.
    for (int k = 1; k <= 1000; k++) begin
      step(mk("long user run", 32'(700 + k), 1'b1, 2'd2, 4'b1011));
    end
    step(withQ(mk("quantum 255 loaded", 32'd1701, 1'b1, 2'd2, 4'b1011), 8'd255));
    step(withQexp(mk("saturated expiry", 32'd0, 1'b0, 2'd2, 4'b1011)));
    step(mk("os after sat", 32'd1, 1'b0, 2'd2, 4'b1011));

    // Stall freezes the quantum at count 2 of 3.
    step(withQ(mk("quantum 3", 32'd2, 1'b0, 2'd2, 4'b1011), 8'd3));
    step(withDisp(mk("dispatch ctx2 again", 32'd1702, 1'b1, 2'd2, 4'b1011), 2'd2));
    step(withDisp(mk("user dispatch ignored", 32'd1703, 1'b1, 2'd2, 4'b1011), 2'd2));
    step(mk("user run 1704", 32'd1704, 1'b1, 2'd2, 4'b1011));
    step(withHalt(withStall(mk("stall halt", 32'd1704, 1'b1, 2'd2, 4'b1011))));
    step(withJump(withStall(mk("stall jump", 32'd1704, 1'b1, 2'd2, 4'b1011)), 32'd50));
    step(withDisp(withStall(mk("stall dispatch", 32'd1704, 1'b1, 2'd2, 4'b1011)), 2'd1));
    step(withStall(mk("stall 4", 32'd1704, 1'b1, 2'd2, 4'b1011)));
    step(withStall(mk("stall 5", 32'd1704, 1'b1, 2'd2, 4'b1011)));
    step(withQexp(mk("expiry after stall", 32'd0, 1'b0, 2'd2, 4'b1011)));
    step(withStall(mk("stall clears pulse", 32'd0, 1'b0, 2'd2, 4'b1011)));
    step(mk("os resume", 32'd1, 1'b0, 2'd2, 4'b1011));
    step(withDisp(mk("resume ctx2 1705", 32'd1705, 1'b1, 2'd2, 4'b1011), 2'd2));
    step(withPend(withHalt(mk("halt ctx2", 32'd0, 1'b0, 2'd2, 4'b1111))));

    // Init and dispatch of the same context in one cycle, then a low user jump.
    step(withDisp(withInit(mk("init+dispatch ctx3", 32'd900, 1'b1, 2'd3, 4'b0111), 2'd3, 32'd900), 2'd3));
`ifdef PC_BOUNDS_CHECK_EN
    step(withFault(withJump(mk("low jump traps", 32'd0, 1'b0, 2'd3, 4'b1111), 32'd100)));
    step(mk("os after trap", 32'd1, 1'b0, 2'd3, 4'b1111));
    step(withDisp(withInit(mk("enter ctx0 600", 32'd600, 1'b1, 2'd0, 4'b1110), 2'd0, 32'd600), 2'd0));
    step(mk("user run 601", 32'd601, 1'b1, 2'd0, 4'b1110));
`else
    step(withJump(mk("low jump honoured", 32'd100, 1'b1, 2'd3, 4'b0111), 32'd100));
    step(mk("user run 101", 32'd101, 1'b1, 2'd3, 4'b0111));
    step(withQexp(mk("low addr expiry", 32'd0, 1'b0, 2'd3, 4'b0111)));
    step(withDisp(withInit(mk("enter ctx0 600", 32'd600, 1'b1, 2'd0, 4'b0110), 2'd0, 32'd600), 2'd0));
    step(mk("user run 601", 32'd601, 1'b1, 2'd0, 4'b0110));
`endif

    // Asynchronous reset in the middle of a user cycle.
    #2;
    reset = 1'b0;
    #1;
    expQ.push_back(mk("async reset", 32'd0, 1'b0, 2'd0, 4'b1111));
    checkOutput();
    @(posedge clock);
    #1;
    expQ.push_back(mk("held in reset", 32'd0, 1'b0, 2'd0, 4'b1111));
    checkOutput();
    reset = 1'b1;
    step(idle.name == "" ? idle : mk("after reset", 32'd1, 1'b0, 2'd0, 4'b1111));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
